// File: rtl/baccarat_pkg.sv
// Shared types, thresholds and the card-value helper for the Punto Banco round sequencer.
package baccarat_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        NATCHECK,
        DRAW_P3,
        BANK_DECIDE,
        DRAW_D3,
        RESULT,
        DONE
    } state_t;

    // A two-card total at or above this is a natural and ends the round.
    localparam logic [3:0] NATURAL_MIN = 4'd8;
    // A side stands on totals at or above this when deciding a third card.
    localparam logic [3:0] STAND_MIN   = 4'd6;

    // Point value of a raw card code: tens and court cards count zero.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        return (code >= 4'd10) ? 4'd0 : code;
    endfunction

endpackage

// File: rtl/bank_draw_rule.sv
// Banker third-card tableau, used once the player has drawn a third card.
module bank_draw_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] w_value;

    assign w_value = card_value(pcard3);

    // Decide whether the banker draws from its total and the player's third card value.
    always_comb begin
        // NOTE: draw is defaulted before the case so no branch leaves it unassigned (no latch).
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (w_value != 4'd8);
            4'd4:             draw = (w_value >= 4'd2) && (w_value <= 4'd7);
            4'd5:             draw = (w_value >= 4'd4) && (w_value <= 4'd7);
            4'd6:             draw = (w_value >= 4'd6) && (w_value <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_round_ctrl.sv
// Round sequencer: deals four cards, applies natural and third-card rules, lights the winner.
module baccarat_round_ctrl
    import baccarat_pkg::*;
#(
    parameter bit AUTO_ADVANCE = 1'b0
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       start,
    input  logic       advance,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       clear_cards,
    output logic       busy,
    output logic       done,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    state_t r_state;
    state_t w_next;
    logic   r_player_win;
    logic   r_dealer_win;
    logic   w_adv;
    logic   w_bank_draw;
    logic   w_set_lights;
    logic   w_clr_lights;

    assign w_adv = advance | AUTO_ADVANCE;

    bank_draw_rule u_bank_draw_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (w_bank_draw)
    );

    // State register; reset returns to IDLE.
    always_ff @(posedge slow_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state plus Mealy load/clear pulses; every pulse is suppressed while reset is high.
    always_comb begin
        w_next       = r_state;
        load_pcard1  = 1'b0;
        load_pcard2  = 1'b0;
        load_pcard3  = 1'b0;
        load_dcard1  = 1'b0;
        load_dcard2  = 1'b0;
        load_dcard3  = 1'b0;
        clear_cards  = 1'b0;
        w_set_lights = 1'b0;
        w_clr_lights = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: if (start) begin
                    clear_cards = 1'b1;
                    w_next      = DEAL_P1;
                end
                DEAL_P1: if (w_adv) begin
                    load_pcard1 = 1'b1;
                    w_next      = DEAL_D1;
                end
                DEAL_D1: if (w_adv) begin
                    load_dcard1 = 1'b1;
                    w_next      = DEAL_P2;
                end
                DEAL_P2: if (w_adv) begin
                    load_pcard2 = 1'b1;
                    w_next      = DEAL_D2;
                end
                DEAL_D2: if (w_adv) begin
                    load_dcard2 = 1'b1;
                    w_next      = NATCHECK;
                end
                NATCHECK: begin
                    if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) w_next = RESULT;
                    else if (pscore < STAND_MIN)                        w_next = DRAW_P3;
                    else if (dscore < STAND_MIN)                        w_next = DRAW_D3;
                    else                                                w_next = RESULT;
                end
                DRAW_P3: if (w_adv) begin
                    load_pcard3 = 1'b1;
                    w_next      = BANK_DECIDE;
                end
                BANK_DECIDE: w_next = w_bank_draw ? DRAW_D3 : RESULT;
                DRAW_D3: if (w_adv) begin
                    load_dcard3 = 1'b1;
                    w_next      = RESULT;
                end
                RESULT: begin
                    w_set_lights = 1'b1;
                    w_next       = DONE;
                end
                DONE: if (start) begin
                    clear_cards  = 1'b1;
                    w_clr_lights = 1'b1;
                    w_next       = DEAL_P1;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Win lights: latched in RESULT, cleared by reset or by a new round started from DONE.
    always_ff @(posedge slow_clock) begin
        if (reset || w_clr_lights) begin
            r_player_win <= 1'b0;
            r_dealer_win <= 1'b0;
        end else if (w_set_lights) begin
            r_player_win <= (pscore >= dscore);
            r_dealer_win <= (pscore <= dscore);
        end
    end

    assign busy             = (r_state != IDLE) && (r_state != DONE);
    assign done             = (r_state == DONE);
    assign player_win_light = r_player_win;
    assign dealer_win_light = r_dealer_win;

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Bench for the round sequencer: plays real card registers and scorehand totals around the DUT,
// predicts each round from the Punto Banco rules, and checks pulses and lights every cycle.
module tb_baccarat_round_ctrl;

    localparam logic [6:0] EV_P1  = 7'b1000000;
    localparam logic [6:0] EV_D1  = 7'b0100000;
    localparam logic [6:0] EV_P2  = 7'b0010000;
    localparam logic [6:0] EV_D2  = 7'b0001000;
    localparam logic [6:0] EV_P3  = 7'b0000100;
    localparam logic [6:0] EV_D3  = 7'b0000010;
    localparam logic [6:0] EV_CLR = 7'b0000001;

    logic clk = 1'b0;
    logic reset, start, advance;
    logic [3:0] pscore, dscore, pcard3;
    logic load_pcard1, load_pcard2, load_pcard3;
    logic load_dcard1, load_dcard2, load_dcard3;
    logic clear_cards, busy, done, player_win_light, dealer_win_light;

    // second instance with the free-running option, fed fixed totals
    logic       start_a;
    logic [3:0] pscore_a, dscore_a;
    logic [3:0] pcard3_a = 4'd0;
    logic a_p1, a_p2, a_p3, a_d1, a_d2, a_d3, a_clr, a_busy, a_done, a_pw, a_dw;

    // stand-alone tableau instance
    logic [3:0] ut_d, ut_c;
    logic       ut_draw;

    int n_total = 0;
    int n_bad   = 0;

    // card registers the DUT loads; deck holds the six cards of the current round
    int         deck [6];
    logic [3:0] pc1 = '0, pc2 = '0, pc3 = '0, dc1 = '0, dc2 = '0, dc3 = '0;

    // banker tableau: bit v of row t set means banker on t draws against player third card value v
    logic [9:0] tab [0:7];

    logic [6:0] exp_q [$];
    logic [1:0] exp_lights  = 2'b00;
    logic [1:0] pend_lights = 2'b00;
    bit         chk_en      = 1'b0;
    logic [6:0] pv;
    int cnt_p3 = 0, cnt_d3 = 0, cnt_pulse = 0;
    int a_n_load = 0, a_n_p3 = 0, a_n_d3 = 0, a_n_clr = 0;

    always #5 clk = ~clk;

    baccarat_round_ctrl #(.AUTO_ADVANCE(1'b0)) dut (
        .slow_clock(clk), .reset(reset), .start(start), .advance(advance),
        .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
        .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
        .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
        .clear_cards(clear_cards), .busy(busy), .done(done),
        .player_win_light(player_win_light), .dealer_win_light(dealer_win_light)
    );

    baccarat_round_ctrl #(.AUTO_ADVANCE(1'b1)) dut_auto (
        .slow_clock(clk), .reset(reset), .start(start_a), .advance(1'b0),
        .pscore(pscore_a), .dscore(dscore_a), .pcard3(pcard3_a),
        .load_pcard1(a_p1), .load_pcard2(a_p2), .load_pcard3(a_p3),
        .load_dcard1(a_d1), .load_dcard2(a_d2), .load_dcard3(a_d3),
        .clear_cards(a_clr), .busy(a_busy), .done(a_done),
        .player_win_light(a_pw), .dealer_win_light(a_dw)
    );

    bank_draw_rule u_rule (.dscore(ut_d), .pcard3(ut_c), .draw(ut_draw));

    function automatic int cv(input int code);
        return (code >= 10) ? 0 : code;
    endfunction

    function automatic logic [3:0] hand(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return 4'((cv(int'(a)) + cv(int'(b)) + cv(int'(c))) % 10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // card registers behave like the real datapath: clear, then load from the deck
    always @(posedge clk) begin
        if (clear_cards) begin
            pc1 <= '0; pc2 <= '0; pc3 <= '0; dc1 <= '0; dc2 <= '0; dc3 <= '0;
        end
        if (load_pcard1) pc1 <= 4'(deck[0]);
        if (load_dcard1) dc1 <= 4'(deck[1]);
        if (load_pcard2) pc2 <= 4'(deck[2]);
        if (load_dcard2) dc2 <= 4'(deck[3]);
        if (load_pcard3) pc3 <= 4'(deck[4]);
        if (load_dcard3) dc3 <= 4'(deck[5]);
    end

    assign pscore = hand(pc1, pc2, pc3);
    assign dscore = hand(dc1, dc2, dc3);
    assign pcard3 = pc3;

    // per-cycle compare of the main DUT against the predicted event order and lights
    always @(negedge clk) begin
        if (chk_en) begin
            pv = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3, clear_cards};
            check("onehot_pulses", 32'($countones(pv) <= 1), 1);
            if (reset) begin
                check("no_pulse_in_reset", pv, 0);
            end else begin
                check("busy_done_exclusive", busy && done, 0);
                check("lights", {player_win_light, dealer_win_light}, done ? exp_lights : 2'b00);
                if (pv != 7'd0) begin
                    cnt_pulse++;
                    if (load_pcard3) cnt_p3++;
                    if (load_dcard3) cnt_d3++;
                    if (clear_cards) check("clear_needs_start", start, 1);
                    else             check("load_needs_advance", advance, 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", pv, 0);
                    end else begin
                        check("pulse_order", pv, exp_q[0]);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // pulse counters for the free-running instance
    always @(negedge clk) begin
        if (a_p1 || a_p2 || a_d1 || a_d2) a_n_load++;
        if (a_p3)  a_n_p3++;
        if (a_d3)  a_n_d3++;
        if (a_clr) a_n_clr++;
    end

    // predict the round from the deck: natural, player rule, banker tableau, winner
    task automatic setup_round();
        int  pt, bt, pf, bf;
        bit  nat, pd, bd;
        pt  = (cv(deck[0]) + cv(deck[2])) % 10;
        bt  = (cv(deck[1]) + cv(deck[3])) % 10;
        nat = (pt >= 8) || (bt >= 8);
        pd  = !nat && (pt <= 5);
        if (nat)     bd = 1'b0;
        else if (pd) bd = tab[bt][cv(deck[4])];
        else         bd = (bt <= 5);
        pf = (pt + (pd ? cv(deck[4]) : 0)) % 10;
        bf = (bt + (bd ? cv(deck[5]) : 0)) % 10;
        exp_q.delete();
        exp_q.push_back(EV_CLR);
        exp_q.push_back(EV_P1);
        exp_q.push_back(EV_D1);
        exp_q.push_back(EV_P2);
        exp_q.push_back(EV_D2);
        if (pd) exp_q.push_back(EV_P3);
        if (bd) exp_q.push_back(EV_D3);
        pend_lights = {pf >= bf, pf <= bf};
        cnt_p3 = 0;
        cnt_d3 = 0;
    endtask

    task automatic finish_round(input bit rand_adv, inout int lat);
        while (!done && lat < 200) begin
            advance = rand_adv ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            lat++;
        end
        advance = 1'b0;
        check("round_reaches_done", done, 1);
        check("final_lights", {player_win_light, dealer_win_light}, pend_lights);
        check("all_events_seen", exp_q.size(), 0);
    endtask

    task automatic play_round(input bit rand_adv, output int lat);
        setup_round();
        start   = 1'b1;
        advance = rand_adv ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
        start      = 1'b0;
        exp_lights = pend_lights;
        lat        = 1;
        finish_round(rand_adv, lat);
    endtask

    task automatic auto_round(input logic [3:0] ps, input logic [3:0] ds, output int lat);
        pscore_a = ps;
        dscore_a = ds;
        a_n_load = 0; a_n_p3 = 0; a_n_d3 = 0; a_n_clr = 0;
        start_a  = 1'b1;
        step();
        start_a = 1'b0;
        lat     = 1;
        while (!a_done && lat < 50) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, n0;
        tab[0] = 10'h3FF; tab[1] = 10'h3FF; tab[2] = 10'h3FF;
        tab[3] = 10'b10_1111_1111;
        tab[4] = 10'b00_1111_1100;
        tab[5] = 10'b00_1111_0000;
        tab[6] = 10'b00_1100_0000;
        tab[7] = 10'b00_0000_0000;
        deck = '{1, 1, 1, 1, 1, 1};
        reset = 1'b1; start = 1'b1; advance = 1'b1;
        start_a = 1'b0; pscore_a = 4'd0; dscore_a = 4'd0;
        ut_d = 4'd0; ut_c = 4'd0;

        // reset with start and advance high: no pulses, everything idle
        step();
        chk_en = 1'b1;
        step(); step();
        reset = 1'b0; start = 1'b0; advance = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lights", {player_win_light, dealer_win_light}, 2'b00);

        // tableau exhaustively, plus two hand-derived points
        for (int d = 0; d < 10; d++) begin
            for (int c = 0; c < 14; c++) begin
                ut_d = 4'(d);
                ut_c = 4'(c);
                #1;
                check("tableau", ut_draw, (d <= 7) ? 32'(tab[d][cv(c)]) : 32'd0);
            end
        end
        ut_d = 4'd3; ut_c = 4'd8; #1; check("tableau_3_vs_8", ut_draw, 0);
        ut_d = 4'd6; ut_c = 4'd7; #1; check("tableau_6_vs_7", ut_draw, 1);

        // natural: player 8, banker 5
        deck = '{3, 2, 5, 3, 1, 1};
        play_round(1'b0, lat);
        check("nat_latency", lat, 7);
        check("nat_lights", {player_win_light, dealer_win_light}, 2'b10);
        check("nat_no_p3", cnt_p3, 0);
        check("nat_no_d3", cnt_d3, 0);

        // player stands on 6, banker draws on 4 to reach 7
        deck = '{2, 1, 4, 3, 9, 3};
        play_round(1'b0, lat);
        check("stand_latency", lat, 8);
        check("stand_lights", {player_win_light, dealer_win_light}, 2'b01);
        check("stand_no_p3", cnt_p3, 0);
        check("stand_one_d3", cnt_d3, 1);

        // player 2 draws an 8: banker on 3 stands
        deck = '{1, 1, 1, 2, 8, 5};
        play_round(1'b1, lat);
        check("b3v8_no_d3", cnt_d3, 0);
        check("b3v8_lights", {player_win_light, dealer_win_light}, 2'b01);

        // same but the player's third card is a queen: banker draws
        deck = '{1, 1, 1, 2, 12, 2};
        play_round(1'b1, lat);
        check("b3vq_d3", cnt_d3, 1);
        check("b3vq_lights", {player_win_light, dealer_win_light}, 2'b01);

        // tie on 5, then lights hold through advance toggling
        deck = '{2, 1, 3, 4, 10, 9};
        play_round(1'b1, lat);
        check("tie_lights", {player_win_light, dealer_win_light}, 2'b11);
        for (int i = 0; i < 20; i++) begin
            advance = 1'(i % 2);
            step();
        end
        advance = 1'b0;
        check("tie_hold", {player_win_light, dealer_win_light}, 2'b11);

        // start from DONE, then advance gating in DEAL_D1
        deck = '{4, 6, 1, 7, 3, 2};
        setup_round();
        start = 1'b1;
        @(negedge clk);
        check("done_start_clear", clear_cards, 1);
        step();
        start      = 1'b0;
        exp_lights = pend_lights;
        check("start_lights_off", {player_win_light, dealer_win_light}, 2'b00);
        check("start_busy", busy, 1);
        advance = 1'b1;
        @(negedge clk);
        check("first_adv_p1", load_pcard1, 1);
        step();
        advance = 1'b0;
        n0 = cnt_pulse;
        repeat (10) step();
        check("hold_no_loads", cnt_pulse - n0, 0);
        check("hold_busy", busy, 1);
        advance = 1'b1;
        @(negedge clk);
        check("single_adv_d1", load_dcard1, 1);
        step();
        advance = 1'b0;
        check("exactly_one_load", cnt_pulse - n0, 1);
        advance = 1'b1;
        @(negedge clk);
        check("then_p2", load_pcard2, 1);
        step();
        lat = 0;
        finish_round(1'b1, lat);

        // reset in DRAW_P3 with advance high
        deck = '{1, 1, 2, 3, 4, 5};
        setup_round();
        start   = 1'b1;
        advance = 1'b1;
        step();
        start      = 1'b0;
        exp_lights = pend_lights;
        repeat (5) step();
        check("busy_before_reset", busy, 1);
        check("p3_still_due", exp_q.size() > 0 ? 32'(exp_q[0]) : 32'd0, 32'(EV_P3));
        reset = 1'b1;
        @(negedge clk);
        check("reset_blocks_p3", load_pcard3, 0);
        step();
        reset = 1'b0;
        exp_q.delete();
        exp_lights = 2'b00;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_lights", {player_win_light, dealer_win_light}, 2'b00);
        advance = 1'b0;
        step();

        // free-running instance: natural and banker-only latencies
        auto_round(4'd8, 4'd5, lat);
        check("auto_nat_latency", lat, 7);
        check("auto_nat_loads", a_n_load, 4);
        check("auto_nat_p3", a_n_p3, 0);
        check("auto_nat_d3", a_n_d3, 0);
        check("auto_nat_clear", a_n_clr, 1);
        check("auto_nat_lights", {a_pw, a_dw}, 2'b10);
        auto_round(4'd6, 4'd4, lat);
        check("auto_bank_latency", lat, 8);
        check("auto_bank_d3", a_n_d3, 1);
        check("auto_bank_p3", a_n_p3, 0);
        check("auto_bank_lights", {a_pw, a_dw}, 2'b10);

        // random rounds with random advance pacing
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 6; k++) deck[k] = int'($urandom_range(1, 13));
            play_round(1'b1, lat);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
